// File: rtl/button_press_classifier.sv
// -----------------------------------------------------------------------------
// button_press_classifier
//
// Front-end for one raw push-button. The pin is brought into the clock domain
// by a two-flop synchroniser and debounced into a clean pressed level. Each
// press is then classified by a small FSM into short, long and auto-repeat
// events. Every event is a registered single-cycle pulse. Downstream
// digit/LED drivers use these pulses as increment and mode strobes.
//
// Parameters
//   DEBOUNCE_CYCLES : number of consecutive cycles that the synchronised level
//                     must disagree with o_level before o_level follows it
//                     (minimum 2)
//   LONG_CYCLES     : cycles from the press pulse to the long pulse (min 2)
//   REPEAT_CYCLES   : auto-repeat period after the long pulse (min 2)
//   ACTIVE_LEVEL    : raw i_button level that means "pressed"
//
// Ports
//   i_clk          : system clock
//   i_rst          : synchronous reset, active-high
//   i_button       : raw asynchronous button pin
//   i_repeat_en    : 1 = emit repeat pulses while long-held
//   o_level        : debounced pressed level (1 = pressed)
//   o_press_pulse  : one cycle when a press is recognised
//   o_short_pulse  : one cycle on release before the long threshold
//   o_long_pulse   : one cycle when the hold reaches LONG_CYCLES
//   o_repeat_pulse : one cycle per REPEAT_CYCLES while long-held and enabled
// -----------------------------------------------------------------------------
module button_press_classifier #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned LONG_CYCLES     = 50000000,
    parameter int unsigned REPEAT_CYCLES   = 10000000,
    parameter logic        ACTIVE_LEVEL    = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_button,
    input  logic i_repeat_en,
    output logic o_level,
    output logic o_press_pulse,
    output logic o_short_pulse,
    output logic o_long_pulse,
    output logic o_repeat_pulse
);

    // -------------------------------------------------------------------------
    // Counter widths and terminal values
    // -------------------------------------------------------------------------
    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
    localparam int HOLD_W = $clog2(LONG_CYCLES);
    localparam int REP_W  = $clog2(REPEAT_CYCLES);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_CYCLES - 1);

    localparam int SYNC_STAGES = 2;

    // -------------------------------------------------------------------------
    // Synchroniser
    // -------------------------------------------------------------------------
    // The stages reset to the released level. This makes a button that is held
    // through reset look like a fresh press once reset is released.
    logic [SYNC_STAGES-1:0] sync_q;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            logic stage_in;
            if (gi == 0) begin : g_first
                assign stage_in = i_button;
            end else begin : g_chain
                assign stage_in = sync_q[gi-1];
            end

            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    sync_q[gi] <= ~ACTIVE_LEVEL;
                end else begin
                    sync_q[gi] <= stage_in;
                end
            end
        end
    endgenerate

    // Synchronised "pressed" indication. Nothing else looks at i_button.
    logic p_sync;
    assign p_sync = (sync_q[SYNC_STAGES-1] == ACTIVE_LEVEL);

    // -------------------------------------------------------------------------
    // Debounce
    // -------------------------------------------------------------------------
    logic            level_q, level_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;

    always_comb begin
        level_d  = level_q;
        db_cnt_d = db_cnt_q;
        if (p_sync == level_q) begin
            // Agreement (or a bounce back) restarts the qualification window.
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
            level_d  = p_sync;
            db_cnt_d = '0;
        end else begin
            db_cnt_d = db_cnt_q + DB_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            level_q  <= 1'b0;
            db_cnt_q <= '0;
        end else begin
            level_q  <= level_d;
            db_cnt_q <= db_cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Press classifier FSM
    // -------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HELD = 2'd1,
        ST_LONG = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [REP_W-1:0]    rep_cnt_q, rep_cnt_d;
    logic                press_q, press_d;
    logic                short_q, short_d;
    logic                long_q, long_d;
    logic                repeat_q, repeat_d;

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        rep_cnt_d  = rep_cnt_q;
        press_d    = 1'b0;
        short_d    = 1'b0;
        long_d     = 1'b0;
        repeat_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (level_q) begin
                    press_d    = 1'b1;
                    hold_cnt_d = '0;
                    state_d    = ST_HELD;
                end
            end

            ST_HELD: begin
                // Release is tested first. If the release arrives on the same
                // cycle as the threshold, the event is classified as short.
                if (!level_q) begin
                    short_d = 1'b1;
                    state_d = ST_IDLE;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    long_d    = 1'b1;
                    rep_cnt_d = '0;
                    state_d   = ST_LONG;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end

            ST_LONG: begin
                if (!level_q) begin
                    // A long press already reported itself, so the release is
                    // silent.
                    state_d = ST_IDLE;
                end else if (!i_repeat_en) begin
                    // Holding the counter at zero means that re-enabling
                    // starts a full period.
                    rep_cnt_d = '0;
                end else if (rep_cnt_q == REP_LAST) begin
                    repeat_d  = 1'b1;
                    rep_cnt_d = '0;
                end else begin
                    rep_cnt_d = rep_cnt_q + REP_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            hold_cnt_q <= '0;
            rep_cnt_q  <= '0;
            press_q    <= 1'b0;
            short_q    <= 1'b0;
            long_q     <= 1'b0;
            repeat_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            rep_cnt_q  <= rep_cnt_d;
            press_q    <= press_d;
            short_q    <= short_d;
            long_q     <= long_d;
            repeat_q   <= repeat_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign o_level        = level_q;
    assign o_press_pulse  = press_q;
    assign o_short_pulse  = short_q;
    assign o_long_pulse   = long_q;
    assign o_repeat_pulse = repeat_q;

endmodule
